uart_receiver: RTL and testbench

- Serial-in deframer for the UART 16750; receive-side counterpart of the transmitter.
- Samples SIN at 16x baud (RXCLK enable), recovers start/data/parity/stop framing per LCR settings (WLS, PEN, EPS, SP).
- Presents the received word with PE/FE/BI status and a one-cycle RXFINISHED strobe for the RX FIFO write logic.
- Single clock domain (CLK); SIN is asynchronous and synchronised internally.

---
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 16750 receive deframer: synchronises SIN, samples mid-bit at OVERSAMPLE x baud,
// and presents each frame with PE/FE/BI status and a one-cycle RXFINISHED strobe.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       RXCLEAR,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       SIN,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, MWAIT} state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                 ssin;
  logic [TW-1:0]        tick, tick_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [7:0]           shift;
  logic                 par_bit, par_err;
  logic                 clr_frame, take_data, take_par, take_stop;
  logic                 last_bit, par_expect;
  logic                 unused;

  // Only the first stop bit is checked, so the stop-bit count has no effect here.
  assign unused = STB;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], SIN};
  end

  assign ssin       = sync[SYNC_STAGES-1];
  assign last_bit   = (bit_cnt == 3'd4 + {1'b0, WLS});
  assign par_expect = SP ? ~EPS : (EPS ? ^shift : ~^shift);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    tick_next    = tick;
    bit_cnt_next = bit_cnt;
    clr_frame    = 1'b0;
    take_data    = 1'b0;
    take_par     = 1'b0;
    take_stop    = 1'b0;
    if (RXCLK) begin
      case (state)
        IDLE: if (!ssin) begin
          tick_next  = '0;
          state_next = START;
        end
        START: if (tick == TICK_MID) begin
          tick_next = '0;
          if (!ssin) begin
            bit_cnt_next = '0;
            clr_frame    = 1'b1;
            state_next   = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          tick_next = tick + TW'(1);
        end
        DATA: if (tick == TICK_LAST) begin
          tick_next    = '0;
          take_data    = 1'b1;
          bit_cnt_next = bit_cnt + 3'd1;
          if (last_bit) state_next = PEN ? PAR : STOP;
        end else begin
          tick_next = tick + TW'(1);
        end
        PAR: if (tick == TICK_LAST) begin
          tick_next  = '0;
          take_par   = 1'b1;
          state_next = STOP;
        end else begin
          tick_next = tick + TW'(1);
        end
        STOP: if (tick == TICK_LAST) begin
          tick_next  = '0;
          take_stop  = 1'b1;
          state_next = ssin ? IDLE : MWAIT;
        end else begin
          tick_next = tick + TW'(1);
        end
        MWAIT: if (ssin) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    // Abort wins over everything, including a stop bit completing this cycle.
    if (RXCLEAR) begin
      state_next   = IDLE;
      tick_next    = '0;
      bit_cnt_next = '0;
      clr_frame    = 1'b1;
      take_data    = 1'b0;
      take_par     = 1'b0;
      take_stop    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift      <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      DOUT       <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= take_stop;
      if (clr_frame) begin
        shift   <= '0;
        par_bit <= 1'b0;
        par_err <= 1'b0;
      end
      if (take_data) shift[bit_cnt] <= ssin;
      if (take_par) begin
        par_bit <= ssin;
        par_err <= ssin ^ par_expect;
      end
      if (take_stop) begin
        DOUT <= shift;
        PE   <= PEN & par_err;
        FE   <= ~ssin;
        BI   <= (shift == '0) & ~(PEN & par_bit) & ~ssin;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: bit-timed SIN frames with hand-computed results.
module tb_uart_receiver;

  localparam int unsigned OS       = 16;
  localparam int unsigned RXDIV    = 4;
  localparam int unsigned BIT_CLKS = OS * RXDIV;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXCLK = 1'b0;
  logic       RXCLEAR = 1'b0;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic       SIN = 1'b1;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;

  int total = 0;
  int bad   = 0;

  int         fin_count = 0;
  logic [7:0] cap_dout [16];
  logic       cap_pe   [16];
  logic       cap_fe   [16];
  logic       cap_bi   [16];
  int unsigned div = 0;

  uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .SIN(SIN),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .RXFINISHED(RXFINISHED)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    div   = (div == RXDIV - 1) ? 0 : div + 1;
    RXCLK = (div == 0);
  end

  always @(negedge CLK) begin
    if (RXFINISHED) begin
      cap_dout[fin_count % 16] = DOUT;
      cap_pe[fin_count % 16]   = PE;
      cap_fe[fin_count % 16]   = FE;
      cap_bi[fin_count % 16]   = BI;
      fin_count = fin_count + 1;
    end
  end

  task automatic cfg(input logic [1:0] w, input logic pen, input logic eps, input logic sp);
    WLS = w; PEN = pen; EPS = eps; SP = sp;
  endtask

  task automatic send_bit(input logic b);
    SIN = b;
    repeat (BIT_CLKS) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned n,
                            input logic use_par, input logic par, input logic stop);
    send_bit(1'b0);
    for (int unsigned i = 0; i < n; i++) send_bit(d[i]);
    if (use_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if ({DOUT, PE, FE, BI, RXFINISHED} !== 12'h000) begin
      bad++; $display("FAIL reset_outputs got=%h want=000", {DOUT, PE, FE, BI, RXFINISHED});
    end
    RST = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    total++; if (fin_count !== 0) begin
      bad++; $display("FAIL reset_idle_pulses got=%0d want=0", fin_count);
    end
  endtask

  task automatic test_8n1;
    int base;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    base = fin_count;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 1) begin
      bad++; $display("FAIL 8n1_pulses got=%0d want=1", fin_count - base);
    end
    total++; if (cap_dout[base % 16] !== 8'hA5) begin
      bad++; $display("FAIL 8n1_dout got=%h want=a5", cap_dout[base % 16]);
    end
    total++; if ({cap_pe[base % 16], cap_fe[base % 16], cap_bi[base % 16]} !== 3'b000) begin
      bad++; $display("FAIL 8n1_status got=%b want=000",
                      {cap_pe[base % 16], cap_fe[base % 16], cap_bi[base % 16]});
    end
  endtask

  task automatic test_parity;
    int base;
    // 5E1, data 10011 has three ones, so even parity expects 1; upper bits must be dropped
    cfg(2'b00, 1'b1, 1'b1, 1'b0);
    base = fin_count;
    send_frame(8'hF3, 5, 1'b1, 1'b0, 1'b1);
    send_frame(8'hF3, 5, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 2) begin
      bad++; $display("FAIL 5e1_pulses got=%0d want=2", fin_count - base);
    end
    total++; if (cap_dout[base % 16] !== 8'h13) begin
      bad++; $display("FAIL 5e1_dout got=%h want=13", cap_dout[base % 16]);
    end
    total++; if ({cap_pe[base % 16], cap_fe[base % 16]} !== 2'b10) begin
      bad++; $display("FAIL 5e1_bad_par got=%b want=10", {cap_pe[base % 16], cap_fe[base % 16]});
    end
    total++; if (cap_pe[(base + 1) % 16] !== 1'b0) begin
      bad++; $display("FAIL 5e1_good_par got=%b want=0", cap_pe[(base + 1) % 16]);
    end
    // 6O1, data 101101 has four ones, odd parity expects 1
    cfg(2'b01, 1'b1, 1'b0, 1'b0);
    base = fin_count;
    send_frame(8'h2D, 6, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1);
    total++; if ({cap_dout[base % 16], cap_pe[base % 16]} !== 9'h05A) begin
      bad++; $display("FAIL 6o1_frame got=%h want=05a", {cap_dout[base % 16], cap_pe[base % 16]});
    end
    // 7-bit stick parity with EPS=0 expects a 1
    cfg(2'b10, 1'b1, 1'b0, 1'b1);
    base = fin_count;
    send_frame(8'hAA, 7, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if (cap_dout[base % 16] !== 8'h2A) begin
      bad++; $display("FAIL stick_dout got=%h want=2a", cap_dout[base % 16]);
    end
    total++; if (cap_pe[base % 16] !== 1'b1) begin
      bad++; $display("FAIL stick_pe got=%b want=1", cap_pe[base % 16]);
    end
  endtask

  task automatic test_false_start;
    int base;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    base = fin_count;
    SIN = 1'b0;
    repeat (6 * RXDIV) @(negedge CLK);
    send_bit(1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 0) begin
      bad++; $display("FAIL false_start_pulses got=%0d want=0", fin_count - base);
    end
    total++; if (DOUT !== 8'h2A) begin
      bad++; $display("FAIL false_start_dout got=%h want=2a", DOUT);
    end
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 1 || cap_dout[base % 16] !== 8'h96) begin
      bad++; $display("FAIL false_start_recover got=%0d/%h want=1/96", fin_count - base, cap_dout[base % 16]);
    end
  endtask

  task automatic test_framing;
    int base;
    base = fin_count;
    send_frame(8'h3F, 8, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    total++; if ({cap_dout[base % 16], cap_fe[base % 16], cap_bi[base % 16]} !== 10'h0FE) begin
      bad++; $display("FAIL framing got=%h want=0fe",
                      {cap_dout[base % 16], cap_fe[base % 16], cap_bi[base % 16]});
    end
  endtask

  task automatic test_break;
    int base;
    base = fin_count;
    SIN = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge CLK);
    total++; if (fin_count - base !== 1) begin
      bad++; $display("FAIL break_pulses got=%0d want=1", fin_count - base);
    end
    total++; if ({cap_dout[base % 16], cap_fe[base % 16], cap_bi[base % 16]} !== 10'h003) begin
      bad++; $display("FAIL break_status got=%h want=003",
                      {cap_dout[base % 16], cap_fe[base % 16], cap_bi[base % 16]});
    end
    send_bit(1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 1) begin
      bad++; $display("FAIL break_release got=%0d want=1", fin_count - base);
    end
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if ({cap_dout[(base + 1) % 16], cap_fe[(base + 1) % 16], cap_bi[(base + 1) % 16]} !== 10'h30C) begin
      bad++; $display("FAIL break_next got=%h want=30c",
                      {cap_dout[(base + 1) % 16], cap_fe[(base + 1) % 16], cap_bi[(base + 1) % 16]});
    end
  endtask

  task automatic test_rxclear;
    int base;
    logic [7:0] d;
    d = 8'h55;
    base = fin_count;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 3; i++) send_bit(d[i]);
    SIN = d[3];
    repeat (BIT_CLKS / 4) @(negedge CLK);
    // Held through the rest of the frame so the remaining low bits cannot re-arm a start.
    RXCLEAR = 1'b1;
    repeat (BIT_CLKS - BIT_CLKS / 4) @(negedge CLK);
    for (int unsigned i = 4; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    RXCLEAR = 1'b0;
    send_bit(1'b1);
    total++; if (fin_count - base !== 0) begin
      bad++; $display("FAIL rxclear_pulses got=%0d want=0", fin_count - base);
    end
    total++; if (DOUT !== 8'hC3) begin
      bad++; $display("FAIL rxclear_hold got=%h want=c3", DOUT);
    end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 1 || cap_dout[base % 16] !== 8'h3C) begin
      bad++; $display("FAIL rxclear_next got=%0d/%h want=1/3c", fin_count - base, cap_dout[base % 16]);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = fin_count;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 2) begin
      bad++; $display("FAIL b2b_pulses got=%0d want=2", fin_count - base);
    end
    total++; if ({cap_dout[base % 16], cap_dout[(base + 1) % 16]} !== 16'h817E) begin
      bad++; $display("FAIL b2b_data got=%h want=817e", {cap_dout[base % 16], cap_dout[(base + 1) % 16]});
    end
  endtask

  task automatic test_rst_midframe;
    int base;
    logic [7:0] d;
    d = 8'h77;
    base = fin_count;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 3; i++) send_bit(d[i]);
    RST = 1'b1;
    SIN = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if ({DOUT, PE, FE, BI, RXFINISHED} !== 12'h000) begin
      bad++; $display("FAIL rst_mid_outputs got=%h want=000", {DOUT, PE, FE, BI, RXFINISHED});
    end
    RST = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    total++; if (fin_count - base !== 0) begin
      bad++; $display("FAIL rst_mid_pulses got=%0d want=0", fin_count - base);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_framing();
    test_break();
    test_rxclear();
    test_back_to_back();
    test_rst_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
